// File: rtl/if_fetch_if.sv
// Fetch unit bus bundle: instruction memory port,
// decode-side instruction handshake, redirect and status.
interface if_fetch_if;
    logic [15:0] mem_addr;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_err;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] instr_pc_next;
    logic        instr_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halted;
    logic        fault;
    logic [15:0] fault_pc;

    modport master (
        output mem_addr, mem_en, mem_wr, mem_wdata,
        input  mem_rdata, mem_err,
        output instr_valid, instr, instr_pc, instr_pc_next,
        input  instr_ready,
        input  redirect_valid, redirect_pc,
        output halted, fault, fault_pc
    );

    modport slave (
        input  mem_addr, mem_en, mem_wr, mem_wdata,
        output mem_rdata, mem_err,
        input  instr_valid, instr, instr_pc, instr_pc_next,
        output instr_ready,
        output redirect_valid, redirect_pc,
        input  halted, fault, fault_pc
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: PC sequencing, small FIFO
// instruction buffer, HALT/FAULT stop states and redirect.
module if_fetch #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          BUF_DEPTH = 2
) (
    input logic        clk,
    input logic        rst,
    if_fetch_if.master bus
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;

    state_t         state;
    state_t         state_nx;
    logic [15:0]    pc;
    logic [15:0]    fault_pc_q;
    logic [CW-1:0]  count;
    logic [AW-1:0]  head;
    logic [AW-1:0]  tail;
    logic [15:0]    buf_instr [BUF_DEPTH];
    logic [15:0]    buf_pc    [BUF_DEPTH];
    logic           pop;
    logic           fetch;
    logic           push;
    logic           is_halt;

    assign pop     = (count != '0) & bus.instr_ready;
    // rst gates the fetch so mem_en drops as soon as reset asserts
    assign fetch   = !rst & (state == RUN) & !bus.redirect_valid
                   & ((count < CW'(BUF_DEPTH)) | pop);
    assign push    = fetch & !bus.mem_err;
    assign is_halt = (bus.mem_rdata[15:11] == 5'b00000);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nx;
    end

    // next state: redirect wins, then memory error, then HALT word
    always_comb begin
        state_nx = state;
        if (bus.redirect_valid)       state_nx = RUN;
        else if (fetch & bus.mem_err) state_nx = FAULT;
        else if (push & is_halt)      state_nx = HALT;
    end

    // status outputs decoded from state
    always_comb begin
        bus.halted = 1'b0;
        bus.fault  = 1'b0;
        unique case (1'b1)
            state == HALT:  bus.halted = 1'b1;
            state == FAULT: bus.fault  = 1'b1;
            default: ;
        endcase
    end

    // PC, buffer pointers, occupancy and fault address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            count      <= '0;
            head       <= '0;
            tail       <= '0;
            fault_pc_q <= 16'h0000;
        end else if (bus.redirect_valid) begin
            pc    <= bus.redirect_pc;
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (push) begin
                pc   <= pc + 16'd2;
                tail <= tail + AW'(1);
            end
            if (pop) head <= head + AW'(1);
            if (push & !pop)      count <= count + CW'(1);
            else if (pop & !push) count <= count - CW'(1);
            if (fetch & bus.mem_err) fault_pc_q <= pc;
        end
    end

    // buffer storage needs no reset; count qualifies validity
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[tail] <= bus.mem_rdata;
            buf_pc[tail]    <= pc;
        end
    end

    assign bus.mem_addr      = pc;
    assign bus.mem_en        = fetch;
    assign bus.mem_wr        = 1'b0;
    assign bus.mem_wdata     = 16'h0000;
    assign bus.instr_valid   = (count != '0);
    assign bus.instr         = buf_instr[head];
    assign bus.instr_pc      = buf_pc[head];
    assign bus.instr_pc_next = buf_pc[head] + 16'd2;
    assign bus.fault_pc      = fault_pc_q;
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: streaming, backpressure,
// HALT, redirect into fault, PC wrap and async reset.
module tb_if_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    logic [15:0] mem [0:32767];
    logic [15:0] exp_w [4];

    if_fetch_if bus ();

    if_fetch #(.RESET_PC(16'h0000), .BUF_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr[15:1]];
    assign bus.mem_err   = bus.mem_en & bus.mem_addr[0];

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (bus.mem_en !== 1'b0) begin
            errors++; $display("FAIL rst_mem_en: got %b want 0", bus.mem_en);
        end
        vectors++;
        if (bus.instr_valid !== 1'b0) begin
            errors++; $display("FAIL rst_valid: got %b want 0", bus.instr_valid);
        end
        vectors++;
        if ({bus.halted, bus.fault} !== 2'b00) begin
            errors++; $display("FAIL rst_status: got %b want 00", {bus.halted, bus.fault});
        end
        vectors++;
        if (bus.mem_addr !== 16'h0000) begin
            errors++; $display("FAIL rst_addr: got %h want 0000", bus.mem_addr);
        end
        vectors++;
        if ({bus.mem_wr, bus.mem_wdata} !== 17'h0) begin
            errors++; $display("FAIL rst_wr: got %h want 0", {bus.mem_wr, bus.mem_wdata});
        end
    endtask

    task automatic test_stream();
        bus.instr_ready = 1'b1;
        do_reset();
        #1;
        vectors++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== 16'h0000) begin
            errors++; $display("FAIL stream_first: got en=%b addr=%h want en=1 addr=0000", bus.mem_en, bus.mem_addr);
        end
        vectors++;
        if (bus.instr_valid !== 1'b0) begin
            errors++; $display("FAIL stream_latency: got valid=%b want 0", bus.instr_valid);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (bus.instr_valid !== 1'b1 || bus.instr !== exp_w[k]
                || bus.instr_pc !== 16'(2 * k)) begin
                errors++;
                $display("FAIL stream_%0d: got v=%b %h@%h want 1 %h@%h", k, bus.instr_valid, bus.instr, bus.instr_pc, exp_w[k], 16'(2 * k));
            end
            vectors++;
            if (bus.instr_pc_next !== 16'(2 * k + 2)) begin
                errors++; $display("FAIL stream_next_%0d: got %h want %h", k, bus.instr_pc_next, 16'(2 * k + 2));
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        n = 0;
        bus.instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            #1;
            if (bus.mem_en === 1'b1) n++;
            @(negedge clk);
        end
        vectors++;
        if (n !== 2) begin
            errors++; $display("FAIL bp_fetches: got %0d want 2", n);
        end
        #1;
        vectors++;
        if (bus.mem_en !== 1'b0 || bus.mem_addr !== 16'h0004) begin
            errors++; $display("FAIL bp_stall: got en=%b pc=%h want en=0 pc=0004", bus.mem_en, bus.mem_addr);
        end
        bus.instr_ready = 1'b1;
        #1;
        vectors++;
        if (bus.mem_en !== 1'b1) begin
            errors++; $display("FAIL bp_pop_fetch: got en=%b want 1", bus.mem_en);
        end
        for (int k = 0; k < 4; k++) begin
            if (k != 0) begin
                @(negedge clk);
                #1;
            end
            vectors++;
            if (bus.instr_valid !== 1'b1 || bus.instr !== exp_w[k]
                || bus.instr_pc !== 16'(2 * k)) begin
                errors++;
                $display("FAIL bp_order_%0d: got v=%b %h@%h want 1 %h@%h", k, bus.instr_valid, bus.instr, bus.instr_pc, exp_w[k], 16'(2 * k));
            end
        end
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_halt();
        mem[2] = 16'h0000;
        bus.instr_ready = 1'b1;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (bus.instr !== 16'h0000 || bus.instr_pc !== 16'h0004 || bus.instr_valid !== 1'b1) begin
            errors++; $display("FAIL halt_push: got v=%b %h@%h want 1 0000@0004", bus.instr_valid, bus.instr, bus.instr_pc);
        end
        vectors++;
        if (bus.halted !== 1'b1 || bus.mem_en !== 1'b0) begin
            errors++; $display("FAIL halt_state: got halted=%b en=%b want 1 0", bus.halted, bus.mem_en);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (bus.instr_valid !== 1'b0 || bus.halted !== 1'b1 || bus.mem_en !== 1'b0) begin
            errors++; $display("FAIL halt_hold: got v=%b h=%b en=%b want 0 1 0", bus.instr_valid, bus.halted, bus.mem_en);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0100;
        #1;
        vectors++;
        if (bus.mem_en !== 1'b0) begin
            errors++; $display("FAIL halt_redir_nofetch: got en=%b want 0", bus.mem_en);
        end
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        vectors++;
        if (bus.halted !== 1'b0 || bus.mem_en !== 1'b1 || bus.mem_addr !== 16'h0100) begin
            errors++; $display("FAIL halt_redir: got h=%b en=%b addr=%h want 0 1 0100", bus.halted, bus.mem_en, bus.mem_addr);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (bus.instr !== 16'h8080 || bus.instr_pc !== 16'h0100) begin
            errors++; $display("FAIL halt_target: got %h@%h want 8080@0100", bus.instr, bus.instr_pc);
        end
        mem[2] = 16'h3333;
    endtask

    task automatic test_redirect_fault();
        bus.instr_ready = 1'b0;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (bus.instr_valid !== 1'b1 || bus.mem_en !== 1'b0) begin
            errors++; $display("FAIL rf_full: got v=%b en=%b want 1 0", bus.instr_valid, bus.mem_en);
        end
        bus.instr_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0201;
        #1;
        vectors++;
        if (bus.mem_en !== 1'b0) begin
            errors++; $display("FAIL rf_nofetch: got en=%b want 0", bus.mem_en);
        end
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        vectors++;
        if (bus.instr_valid !== 1'b0 || bus.mem_en !== 1'b1 || bus.mem_addr !== 16'h0201) begin
            errors++; $display("FAIL rf_flush: got v=%b en=%b addr=%h want 0 1 0201", bus.instr_valid, bus.mem_en, bus.mem_addr);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (bus.fault !== 1'b1 || bus.fault_pc !== 16'h0201) begin
            errors++; $display("FAIL rf_fault: got fault=%b pc=%h want 1 0201", bus.fault, bus.fault_pc);
        end
        vectors++;
        if (bus.instr_valid !== 1'b0 || bus.mem_en !== 1'b0 || bus.halted !== 1'b0) begin
            errors++; $display("FAIL rf_stop: got v=%b en=%b h=%b want 0 0 0", bus.instr_valid, bus.mem_en, bus.halted);
        end
    endtask

    task automatic test_wrap();
        bus.instr_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'hFFFE;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        vectors++;
        if (bus.fault !== 1'b0 || bus.mem_en !== 1'b1 || bus.mem_addr !== 16'hFFFE) begin
            errors++; $display("FAIL wrap_start: got f=%b en=%b addr=%h want 0 1 fffe", bus.fault, bus.mem_en, bus.mem_addr);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (bus.instr !== 16'hFFFF || bus.instr_pc !== 16'hFFFE || bus.instr_pc_next !== 16'h0000) begin
            errors++; $display("FAIL wrap_entry: got %h@%h next=%h want ffff@fffe next=0000", bus.instr, bus.instr_pc, bus.instr_pc_next);
        end
        vectors++;
        if (bus.mem_addr !== 16'h0000 || bus.fault_pc !== 16'h0201) begin
            errors++; $display("FAIL wrap_pc: got addr=%h fpc=%h want 0000 0201", bus.mem_addr, bus.fault_pc);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (bus.instr !== 16'h1111 || bus.instr_pc !== 16'h0000) begin
            errors++; $display("FAIL wrap_next: got %h@%h want 1111@0000", bus.instr, bus.instr_pc);
        end
    endtask

    task automatic test_async_reset();
        mem[1] = 16'h0000;
        bus.instr_ready = 1'b0;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (bus.halted !== 1'b1 || bus.instr_valid !== 1'b1 || bus.mem_en !== 1'b0) begin
            errors++; $display("FAIL ar_pre: got h=%b v=%b en=%b want 1 1 0", bus.halted, bus.instr_valid, bus.mem_en);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.instr_valid !== 1'b0 || bus.halted !== 1'b0 || bus.fault !== 1'b0) begin
            errors++; $display("FAIL ar_status: got v=%b h=%b f=%b want 0 0 0", bus.instr_valid, bus.halted, bus.fault);
        end
        vectors++;
        if (bus.mem_en !== 1'b0 || bus.mem_addr !== 16'h0000 || bus.fault_pc !== 16'h0000) begin
            errors++; $display("FAIL ar_bus: got en=%b addr=%h fpc=%h want 0 0000 0000", bus.mem_en, bus.mem_addr, bus.fault_pc);
        end
        @(negedge clk);
        rst = 1'b0;
        mem[1] = 16'h2222;
    endtask

    initial begin
        bus.instr_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 16'h0000;
        for (int i = 0; i < 32768; i++) mem[i] = 16'h8000 | 16'(i);
        exp_w[0] = 16'h1111;
        exp_w[1] = 16'h2222;
        exp_w[2] = 16'h3333;
        exp_w[3] = 16'h4444;
        for (int i = 0; i < 4; i++) mem[i] = exp_w[i];
        test_reset();
        test_stream();
        test_backpressure();
        test_halt();
        test_redirect_fault();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter: RESET_PC, default 16'h0000, PC loaded at reset.
REQ-002 Parameter: BUF_DEPTH, default 2, instruction buffer entries; power of two, >=2.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 mem_addr  output  16  fetch byte address to instruction memory.
REQ-006 mem_en  output  1  memory access enable.
REQ-007 mem_wr  output  1  memory write enable; constant 0.
REQ-008 mem_wdata  output  16  memory write data; constant 16'h0000.
REQ-009 mem_rdata  input  16  big-endian instruction word, valid combinationally in the same cycle as mem_en=1.
REQ-010 mem_err  input  1  misaligned-access error, same cycle as mem_en=1.
REQ-011 instr_valid  output  1  buffer head holds an instruction.
REQ-012 instr  output  16  head instruction word.
REQ-013 instr_pc  output  16  address of head instruction.
REQ-014 instr_pc_next  output  16  instr_pc + 2, modulo 2^16.
REQ-015 instr_ready  input  1  consumer accepts head; pop occurs when instr_valid & instr_ready.
REQ-016 redirect_valid  input  1  redirect request (branch/jump/exception).
REQ-017 redirect_pc  input  16  redirect target.
REQ-018 halted  output  1  fetch stopped by HALT instruction.
REQ-019 fault  output  1  fetch stopped by memory error.
REQ-020 fault_pc  output  16  address that raised the error.

Function
REQ-021 State machine with states RUN, HALT, FAULT; halted=1 iff HALT, fault=1 iff FAULT.
REQ-022 Fetch cycle: state RUN, redirect_valid=0, and (count < BUF_DEPTH or pop this cycle); only then mem_en=1, mem_addr=pc; else mem_en=0.
REQ-023 mem_addr shall equal pc in every cycle regardless of mem_en.
REQ-024 Fetch with mem_err=0: push {mem_rdata, pc} at buffer tail; pc <= pc+2, wrapping 16'hFFFE -> 16'h0000.
REQ-025 Fetch with mem_err=1: no push; pc unchanged; fault_pc <= pc; state -> FAULT.
REQ-026 Fetch with mem_rdata[15:11]==5'b00000 (HALT) and mem_err=0: word is pushed, pc <= pc+2, state -> HALT.
REQ-027 Pop and push in the same cycle: both take effect; count unchanged; head advances in order.
REQ-028 Buffer is FIFO; instr/instr_pc present head entry; instr, instr_pc don't-care when instr_valid=0.
REQ-029 Fetched instruction reaches instr_valid no earlier than the cycle after the fetch (one-cycle fetch-to-valid latency when buffer empty).
REQ-030 redirect_valid=1: buffer flushed (count <= 0), pc <= redirect_pc, state -> RUN from any state, no fetch that cycle; a same-cycle pop is discarded by the flush.
REQ-031 Redirect overrides HALT and FAULT; fault_pc retains last value until next fault.
REQ-032 In HALT or FAULT, buffered entries remain poppable; no further fetches.
REQ-033 Odd redirect_pc is accepted; the following fetch raises mem_err and enters FAULT per REQ-025.
REQ-034 No push when full without same-cycle pop; buffer shall never overflow or underflow.

Reset
REQ-035 During rst=1: pc=RESET_PC, count=0, state RUN, fault_pc=16'h0000, mem_en=0, instr_valid=0, halted=0, fault=0.
REQ-036 First fetch occurs in first rising edge cycle after rst deasserts; reset mid-operation discards buffer and pending state immediately.

Verification
REQ-037 Reset release, memory 0x0000..0x0007 = 1111,2222,3333,4444, instr_ready=1 -> instr 16'h1111@0000, 16'h2222@0002, ... one per cycle, instr_pc_next = instr_pc+2.
REQ-038 instr_ready=0 for 5 cycles -> exactly BUF_DEPTH fetches, mem_en=0 thereafter, pc=RESET_PC+2*BUF_DEPTH; release ready -> order preserved, no drops or duplicates.
REQ-039 Word 16'h0000 at 0x0004 -> pushed, halted=1, mem_en=0 afterward; redirect_pc=16'h0100 -> halted=0, next fetch addr 16'h0100.
REQ-040 Buffer full, redirect_valid with instr_ready=1 same cycle, redirect_pc=16'h0201 -> flush, mem_err next cycle, fault=1, fault_pc=16'h0201, instr_valid=0.
REQ-041 redirect_pc=16'hFFFE -> fetch FFFE then 0000; instr_pc_next for FFFE entry = 16'h0000.
REQ-042 rst asserted with 2 entries buffered and state HALT -> outputs per REQ-035 asynchronously, before next clock edge.
